// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Purpose:
//   Multi-cycle control FSM for the PC/IM/RegFile/ALU/DM datapath. Each
//   instruction is walked through FETCH -> DECODE -> execute/memory states.
//   Memory states stall on mem_ready. A wait that exceeds TIMEOUT cycles halts
//   the machine with bus_err. An unsupported opcode halts it with illegal.
//   instr_done pulses on the last cycle of every retired instruction.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   opcode[5:0]    instruction[31:26]; only looked at in DECODE and MEM_ADDR
//   mem_ready      memory access completes this cycle
//   pc_write, pc_write_cond, pc_src[1:0]        PC update controls
//   ir_write, iord, mem_read, mem_write         memory / IR controls
//   mem_to_reg, reg_dst, reg_write              register-file writeback
//   alu_src_a, alu_src_b[1:0], alu_op[1:0]      ALU operand / op selects
//   instr_done     one-cycle pulse on the final cycle of an instruction
//   illegal        sticky: unsupported opcode / state encoding seen
//   bus_err        sticky: memory wait timed out
//   state[3:0]     current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11,
    HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             timeout_hit;
  logic             set_illegal;
  logic             set_bus_err;

  assign state = cur_state;

  // Only FETCH, MEM_RD and MEM_WR wait on memory; the last allowed stall
  // cycle with mem_ready still low is the timeout.
  assign in_wait     = (cur_state == FETCH) || (cur_state == MEM_RD) ||
                       (cur_state == MEM_WR);
  assign timeout_hit = in_wait && !mem_ready && (wait_cnt == CNT_LAST);

  // Next-state decode and sticky-flag set requests.
  always_comb begin
    nxt_state   = cur_state;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (cur_state)
      FETCH: begin
        if (mem_ready) begin
          nxt_state = DECODE;
        end else if (timeout_hit) begin
          nxt_state   = HALT;
          set_bus_err = 1'b1;
        end else begin
          nxt_state = FETCH;
        end
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE:      nxt_state = R_EXEC;
          OP_LW, OP_SW:  nxt_state = MEM_ADDR;
          OP_BEQ:        nxt_state = BRANCH;
          OP_J:          nxt_state = JUMP;
          OP_ADDI:       nxt_state = I_EXEC;
          default: begin
            nxt_state   = HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        // Opcode is re-sampled here; anything other than lw/sw is illegal.
        case (opcode)
          OP_LW:   nxt_state = MEM_RD;
          OP_SW:   nxt_state = MEM_WR;
          default: begin
            nxt_state   = HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEM_RD: begin
        if (mem_ready) begin
          nxt_state = MEM_WB;
        end else if (timeout_hit) begin
          nxt_state   = HALT;
          set_bus_err = 1'b1;
        end else begin
          nxt_state = MEM_RD;
        end
      end
      MEM_WR: begin
        if (mem_ready) begin
          nxt_state = FETCH;
        end else if (timeout_hit) begin
          nxt_state   = HALT;
          set_bus_err = 1'b1;
        end else begin
          nxt_state = MEM_WR;
        end
      end
      MEM_WB:  nxt_state = FETCH;
      R_EXEC:  nxt_state = R_WB;
      R_WB:    nxt_state = FETCH;
      BRANCH:  nxt_state = FETCH;
      JUMP:    nxt_state = FETCH;
      I_EXEC:  nxt_state = I_WB;
      I_WB:    nxt_state = FETCH;
      HALT:    nxt_state = HALT;
      default: begin
        nxt_state   = HALT;
        set_illegal = 1'b1;
      end
    endcase
  end

  // State register, wait counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= FETCH;
      wait_cnt  <= '0;
      illegal   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      // Counter restarts whenever the state changes, so each wait state
      // gets its own full TIMEOUT budget.
      if (nxt_state != cur_state) begin
        wait_cnt <= '0;
      end else if (in_wait && !mem_ready && (wait_cnt != CNT_MAX)) begin
        wait_cnt <= wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt <= wait_cnt;
      end
      illegal <= illegal | set_illegal;
      bus_err <= bus_err | set_bus_err;
    end
  end

  // Per-state control outputs; everything not driven by a state stays 0.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    instr_done    = 1'b0;
    case (cur_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // Mealy loads, gated by rst_n so nothing is written while in reset.
        ir_write  = mem_ready & rst_n;
        pc_write  = mem_ready & rst_n;
      end
      DECODE: begin
        alu_src_b = 2'b11;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

endmodule
